sfifo_fwft_w10_d512: RTL and testbench

Synchronous single-clock FIFO, 10 bits wide and 512 entries deep, with first-word-fall-through (FWFT) output. The head entry is presented on `dout` whenever `empty` is low, and `rd_en` acknowledges (pops) it. The free-queue manager instantiates it as the pointer store that holds free buffer pointers. The manager preloads it at start-up and returns freed pointers on `FQ_wr`; consumers take pointers with `FQ_rd`.

---
 rtl/sfifo_fwft_w10_d512_if.sv | 24 ++
 rtl/sfifo_fwft_w10_d512.sv | 60 ++++++
 tb/tb_sfifo_fwft_w10_d512.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sfifo_fwft_w10_d512_if.sv
// Handshake bundle for the free-pointer FIFO: write side, FWFT read side and status.
// The manager drives through master; the FIFO itself binds to slave.
interface sfifo_fwft_w10_d512_if #(
    parameter int DW = 10,
    parameter int AW = 9
);
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic [AW:0]   data_count;

    modport master (
        output din, wr_en, rd_en,
        input  dout, empty, full, data_count
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, empty, full, data_count
    );
endinterface

// File: rtl/sfifo_fwft_w10_d512.sv
// Single-clock first-word-fall-through FIFO that holds free buffer pointers.
// The head entry is combinationally visible on dout; rd_en pops it.
module sfifo_fwft_w10_d512 #(
    parameter int DW    = 10,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic                   clk,
    input  logic                   rstn,
    sfifo_fwft_w10_d512_if.slave   fif
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          empty, full;
    logic          wr_acc, rd_acc;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);

    // Both acceptances use the pre-edge flags, so a full FIFO drops the write
    // of a simultaneous pair and an empty FIFO ignores the read.
    always_comb begin
        wr_acc = fif.wr_en & ~full;
        rd_acc = fif.rd_en & ~empty;
        wp_d   = wp_q + AW'(wr_acc);
        rp_d   = rp_q + AW'(rd_acc);
        cnt_d  = cnt_q;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately left out of reset; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wp_q] <= fif.din;
    end

    assign fif.dout       = mem_q[rp_q];
    assign fif.empty      = empty;
    assign fif.full       = full;
    assign fif.data_count = cnt_q;
endmodule

// File: tb/tb_sfifo_fwft_w10_d512.sv
// Scoreboard bench: the driver pushes accepted write data into a queue and
// tracks occupancy; a negedge monitor pops on every handshake and checks flags.
module tb_sfifo_fwft_w10_d512;
    localparam int DEPTH = 512;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sfifo_fwft_w10_d512_if #(.DW(10), .AW(9)) fif ();
    sfifo_fwft_w10_d512 dut (.clk(clk), .rstn(rstn), .fif(fif));

    logic [9:0] exp_q [$];
    int mcnt   = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock of stimulus, called just after a rising edge.
    task automatic cyc(input logic w, input logic r, input logic [9:0] d);
        bit wacc, racc;
        wacc = w && (mcnt < DEPTH);
        racc = r && (mcnt > 0);
        fif.wr_en = w;
        fif.rd_en = r;
        fif.din   = d;
        if (wacc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        mcnt = mcnt + int'(wacc) - int'(racc);
        fif.wr_en = 1'b0;
        fif.rd_en = 1'b0;
    endtask

    // Monitor: flags against the model count, data against the scoreboard.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            chk("data_count", int'(fif.data_count), mcnt);
            chk("empty", int'(fif.empty), int'(mcnt == 0));
            chk("full", int'(fif.full), int'(mcnt == DEPTH));
            if (fif.rd_en && !fif.empty) begin
                chk("pop_has_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("dout_order", int'(fif.dout), int'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] d;
        fif.wr_en = 1'b0;
        fif.rd_en = 1'b0;
        fif.din   = '0;
        #12;
        chk("rst_empty", int'(fif.empty), 1);
        chk("rst_full", int'(fif.full), 0);
        chk("rst_count", int'(fif.data_count), 0);
        @(posedge clk); #3 rstn = 1'b1;
        @(posedge clk); #1;

        // Reads on an idle FIFO are ignored
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 10'h0);

        // Single word falls through right after its write edge
        cyc(1'b1, 1'b0, 10'h155);
        chk("fwft_dout", int'(fif.dout), 'h155);
        chk("fwft_empty", int'(fif.empty), 0);
        chk("fwft_count", int'(fif.data_count), 1);
        cyc(1'b0, 1'b1, 10'h0);
        chk("pop_empty", int'(fif.empty), 1);

        // Fill to full, drop one extra write, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 10'(i));
        chk("full_flag", int'(fif.full), 1);
        chk("full_count", int'(fif.data_count), 512);
        cyc(1'b1, 1'b0, 10'h3FF);
        chk("drop_count", int'(fif.data_count), 512);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 10'h0);
        chk("drain_empty", int'(fif.empty), 1);

        // Pointer wrap: 300 in/out, then 400 random in/out across 511->0
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b0, 10'($urandom));
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 10'h0);
        for (int i = 0; i < 400; i++) cyc(1'b1, 1'b0, 10'($urandom));
        chk("wrap_count", int'(fif.data_count), 400);
        for (int i = 0; i < 400; i++) cyc(1'b0, 1'b1, 10'h0);

        // Simultaneous read+write at count 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 10'($urandom));
        cyc(1'b1, 1'b1, 10'h2C3);
        chk("simul5_count", int'(fif.data_count), 5);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 10'h0);

        // Simultaneous at full: read wins, write dropped
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 10'($urandom));
        cyc(1'b1, 1'b1, 10'h2AA);
        chk("simulfull_count", int'(fif.data_count), 511);
        for (int i = 0; i < 511; i++) cyc(1'b0, 1'b1, 10'h0);

        // Simultaneous at empty: write only, word falls through
        cyc(1'b1, 1'b1, 10'h0A5);
        chk("simulempty_count", int'(fif.data_count), 1);
        chk("simulempty_dout", int'(fif.dout), 'h0A5);
        cyc(1'b0, 1'b1, 10'h0);

        // Random mixed traffic
        for (int i = 0; i < 1500; i++) begin
            d = 10'($urandom);
            cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), d);
        end
        while (mcnt > 0) cyc(1'b0, 1'b1, 10'h0);

        // Asynchronous reset mid-cycle with 100 entries stored
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 10'($urandom));
        #2;
        rstn = 1'b0;
        mcnt = 0;
        exp_q.delete();
        #1;
        chk("arst_empty", int'(fif.empty), 1);
        chk("arst_count", int'(fif.data_count), 0);
        chk("arst_full", int'(fif.full), 0);
        @(posedge clk); #3 rstn = 1'b1;
        @(posedge clk); #1;
        cyc(1'b1, 1'b0, 10'h1E7);
        chk("post_rst_dout", int'(fif.dout), 'h1E7);
        cyc(1'b1, 1'b0, 10'h018);
        cyc(1'b0, 1'b1, 10'h0);
        cyc(1'b0, 1'b1, 10'h0);
        chk("post_rst_empty", int'(fif.empty), 1);
        chk("scoreboard_drained", exp_q.size(), 0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
